// File: rtl/mul8_seq.sv
// mul8_seq: sequential shift-and-add unsigned multiplier, one iteration per cycle
module mul8_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               res,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nx;
    logic [2*WIDTH-1:0] mcand, acc, sum;
    logic [WIDTH-1:0]   mplr;
    logic [CW-1:0]      cnt;
    logic               last;

    // next state, per-iteration sum and status outputs decoded from the state register
    always_comb begin
        sum      = acc + (mplr[0] ? mcand : '0);
        last     = (state == RUN) && (cnt == LAST);
        state_nx = (state == IDLE) ? (start ? RUN : IDLE) :
                   (state == RUN)  ? (last ? DONE : RUN) : IDLE;
        busy     = (state == RUN);
        done     = (state == DONE);
    end

    // state register
    always_ff @(posedge clk) begin
        if (res) state <= IDLE;
        else     state <= state_nx;
    end

    // datapath: load operands on accept, shift/add while running, capture product on the last iteration
    always_ff @(posedge clk) begin
        if (res) begin
            mcand <= '0;
            mplr  <= '0;
            acc   <= '0;
            cnt   <= '0;
            p     <= '0;
        end else if (state == IDLE && start) begin
            mcand <= {{WIDTH{1'b0}}, a};
            mplr  <= b;
            acc   <= '0;
            cnt   <= '0;
        end else if (state == RUN) begin
            acc   <= sum;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt + CW'(1);
            if (last) p <= sum;
        end
    end
endmodule

// File: tb/tb_mul8_seq.sv
// tb_mul8_seq: directed, table-driven self-checking bench for mul8_seq
module tb_mul8_seq;
    logic        clk = 1'b0;
    logic        res, start;
    logic [7:0]  a, b;
    logic        busy, done;
    logic [15:0] p;
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs [8];

    mul8_seq dut (
        .clk  (clk),
        .res  (res),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .p    (p)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp);
        logic [15:0] prev;
        prev  = p;
        start = 1'b1;
        a     = x;
        b     = y;
        tick;
        start = 1'b0;
        a     = ~x;
        b     = ~y;
        chk("accept_busy", busy, 1);
        chk("accept_done", done, 0);
        for (int i = 1; i <= 8; i++) begin
            tick;
            if (i < 8) begin
                chk("run_busy", busy, 1);
                chk("run_done", done, 0);
                chk("run_p_hold", p, prev);
            end else begin
                chk("fin_busy", busy, 0);
                chk("fin_done", done, 1);
                chk("fin_p", p, exp);
            end
        end
        tick;
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_p", p, exp);
    endtask

    initial begin
        vecs[0] = '{8'd13,  8'd11,  16'd143};
        vecs[1] = '{8'd255, 8'd255, 16'hFE01};
        vecs[2] = '{8'd0,   8'd200, 16'h0000};
        vecs[3] = '{8'd200, 8'd0,   16'h0000};
        vecs[4] = '{8'd1,   8'd255, 16'h00FF};
        vecs[5] = '{8'd0,   8'd0,   16'h0000};
        vecs[6] = '{8'd170, 8'd85,  16'h3872};
        vecs[7] = '{8'd128, 8'd2,   16'h0100};

        res   = 1'b1;
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            tick;
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_p", p, 16'h0000);
        end
        res   = 1'b0;
        start = 1'b0;
        tick;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_p", p, 16'h0000);

        for (int i = 0; i < 8; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].p);

        run_op(8'd13, 8'd11, 16'd143);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("p_keep", p, 16'd143);
            chk("p_keep_idle", busy, 0);
        end

        start = 1'b1;
        a     = 8'd5;
        b     = 8'd6;
        tick;
        a = 8'd7;
        b = 8'd9;
        chk("sb_accept", busy, 1);
        for (int i = 1; i <= 8; i++) tick;
        chk("sb_done1", done, 1);
        chk("sb_p1", p, 16'd30);
        for (int i = 1; i <= 10; i++) begin
            tick;
            if (i < 10) chk("sb_gap_done", done, 0);
            if (i == 1) chk("sb_ignored", busy, 0);
            if (i == 2) chk("sb_accept2", busy, 1);
            if (i < 10) chk("sb_p1_hold", p, 16'd30);
        end
        start = 1'b0;
        chk("sb_done2", done, 1);
        chk("sb_p2", p, 16'd63);
        tick;

        start = 1'b1;
        a     = 8'd100;
        b     = 8'd100;
        tick;
        start = 1'b0;
        chk("mr_accept", busy, 1);
        tick;
        tick;
        tick;
        chk("mr_run4", busy, 1);
        res = 1'b1;
        tick;
        res = 1'b0;
        chk("mr_busy", busy, 0);
        chk("mr_p", p, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("mr_no_done", done, 0);
            chk("mr_p_zero", p, 16'h0000);
        end
        run_op(8'd3, 8'd4, 16'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
